// File: rtl/adder_axil_sequencer.sv
// AXI4-Lite master that turns each client operand pair into a write-A, write-B, read-SUM
// sequence against the adder peripheral and returns the sum (or an error flag) to the client.
module adder_axil_sequencer #(
   parameter int          C_M_AXI_ADDR_WIDTH = 32,
   parameter int          C_M_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [31:0]                       req_a,
   input  logic [31:0]                       req_b,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [31:0]                       rsp_sum,
   output logic                              rsp_err,
   output logic                              busy,
   output logic [15:0]                       txn_count,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
   output logic [2:0]                        M_AXI_AWPROT,
   output logic                              M_AXI_AWVALID,
   input  logic                              M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
   output logic                              M_AXI_WVALID,
   input  logic                              M_AXI_WREADY,
   input  logic [1:0]                        M_AXI_BRESP,
   input  logic                              M_AXI_BVALID,
   output logic                              M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
   output logic [2:0]                        M_AXI_ARPROT,
   output logic                              M_AXI_ARVALID,
   input  logic                              M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
   input  logic [1:0]                        M_AXI_RRESP,
   input  logic                              M_AXI_RVALID,
   output logic                              M_AXI_RREADY
);

   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_A   = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR);
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_B   = ADDR_A + C_M_AXI_ADDR_WIDTH'(4);
   localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_SUM = ADDR_A + C_M_AXI_ADDR_WIDTH'(8);

   typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_SUM, RESP} state_t;

   state_t                          state;
   logic [C_M_AXI_DATA_WIDTH-1:0]   op_b;
   logic                            aw_done;
   logic                            w_done;
   logic                            ar_done;

   assign M_AXI_AWPROT = 3'b000;
   assign M_AXI_ARPROT = 3'b000;
   assign M_AXI_WSTRB  = '1;

   // Operand A goes straight into WDATA on acceptance; only B needs holding until WR_B.
   // The done flags gate the B/R handshakes so a premature response is ignored.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state         <= IDLE;
         op_b          <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         ar_done       <= 1'b0;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_sum       <= '0;
         rsp_err       <= 1'b0;
         busy          <= 1'b0;
         txn_count     <= '0;
         M_AXI_AWADDR  <= '0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= '0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  op_b          <= C_M_AXI_DATA_WIDTH'(req_b);
                  M_AXI_WDATA   <= C_M_AXI_DATA_WIDTH'(req_a);
                  M_AXI_AWADDR  <= ADDR_A;
                  M_AXI_AWVALID <= 1'b1;
                  M_AXI_WVALID  <= 1'b1;
                  M_AXI_BREADY  <= 1'b1;
                  aw_done       <= 1'b0;
                  w_done        <= 1'b0;
                  rsp_err       <= 1'b0;
                  rsp_sum       <= '0;
                  req_ready     <= 1'b0;
                  busy          <= 1'b1;
                  state         <= WR_A;
               end
            end
            WR_A, WR_B: begin
               if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                  M_AXI_AWVALID <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (M_AXI_WVALID && M_AXI_WREADY) begin
                  M_AXI_WVALID <= 1'b0;
                  w_done       <= 1'b1;
               end
               if (M_AXI_BVALID && M_AXI_BREADY && aw_done && w_done) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  if (M_AXI_BRESP != 2'b00) begin
                     rsp_err      <= 1'b1;
                     rsp_sum      <= '0;
                     rsp_valid    <= 1'b1;
                     M_AXI_BREADY <= 1'b0;
                     state        <= RESP;
                  end else if (state == WR_A) begin
                     M_AXI_AWADDR  <= ADDR_B;
                     M_AXI_WDATA   <= op_b;
                     M_AXI_AWVALID <= 1'b1;
                     M_AXI_WVALID  <= 1'b1;
                     state         <= WR_B;
                  end else begin
                     M_AXI_BREADY  <= 1'b0;
                     M_AXI_ARADDR  <= ADDR_SUM;
                     M_AXI_ARVALID <= 1'b1;
                     M_AXI_RREADY  <= 1'b1;
                     ar_done       <= 1'b0;
                     state         <= RD_SUM;
                  end
               end
            end
            RD_SUM: begin
               if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                  M_AXI_ARVALID <= 1'b0;
                  ar_done       <= 1'b1;
               end
               if (M_AXI_RVALID && M_AXI_RREADY && ar_done) begin
                  rsp_sum      <= 32'(M_AXI_RDATA);
                  rsp_err      <= rsp_err | (M_AXI_RRESP != 2'b00);
                  rsp_valid    <= 1'b1;
                  M_AXI_RREADY <= 1'b0;
                  ar_done      <= 1'b0;
                  state        <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  txn_count <= txn_count + 16'd1;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_axil_sequencer.sv
// Directed bench for adder_axil_sequencer: a small AXI4-Lite adder slave model with
// per-test stalls and error responses, plus hand-computed expected results.
module tb_adder_axil_sequencer;

   logic        ACLK;
   logic        ARESETN;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_sum;
   logic        rsp_err;
   logic        busy;
   logic [15:0] txn_count;
   logic [31:0] M_AXI_AWADDR;
   logic [2:0]  M_AXI_AWPROT;
   logic        M_AXI_AWVALID;
   logic        M_AXI_AWREADY;
   logic [31:0] M_AXI_WDATA;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_WVALID;
   logic        M_AXI_WREADY;
   logic [1:0]  M_AXI_BRESP;
   logic        M_AXI_BVALID;
   logic        M_AXI_BREADY;
   logic [31:0] M_AXI_ARADDR;
   logic [2:0]  M_AXI_ARPROT;
   logic        M_AXI_ARVALID;
   logic        M_AXI_ARREADY;
   logic [31:0] M_AXI_RDATA;
   logic [1:0]  M_AXI_RRESP;
   logic        M_AXI_RVALID;
   logic        M_AXI_RREADY;

   int checks = 0;
   int passed = 0;

   int          aw_delay = 0;
   int          w_delay = 0;
   logic [1:0]  bresp_b = 2'b00;
   logic [1:0]  rresp_cfg = 2'b00;
   logic        rdata_over_en = 1'b0;
   logic [31:0] rdata_over = '0;

   logic [31:0] aw_log[$];
   logic [31:0] w_log[$];
   logic [31:0] ar_log[$];
   int          aw_alone;
   int          w_alone;

   adder_axil_sequencer #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_BASE_ADDR(32'h0000_0000)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
      .busy(busy), .txn_count(txn_count),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Slave model: handshakes are sampled on the falling edge and responses are driven
   // 1 time unit after the rising edge, so ready follows valid within the same cycle.
   initial begin : slave
      logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
      logic        aw_got, w_got, ar_pend;
      logic [31:0] aw_addr_l, w_data_l, reg_a, reg_b;
      int          aw_wait, w_wait;
      aw_got = 0; w_got = 0; ar_pend = 0; aw_wait = 0; w_wait = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
      aw_addr_l = '0; w_data_l = '0; reg_a = '0; reg_b = '0;
      M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = 0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
            aw_got = 0; w_got = 0; ar_pend = 0; aw_wait = 0; w_wait = 0;
         end else begin
            aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
            w_hs  = M_AXI_WVALID && M_AXI_WREADY;
            b_hs  = M_AXI_BVALID && M_AXI_BREADY;
            ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
            r_hs  = M_AXI_RVALID && M_AXI_RREADY;
            if (M_AXI_AWVALID && !M_AXI_WVALID) aw_alone++;
            if (M_AXI_WVALID && !M_AXI_AWVALID) w_alone++;
            if (aw_hs) begin
               aw_log.push_back(M_AXI_AWADDR);
               aw_addr_l = M_AXI_AWADDR; aw_got = 1; aw_wait = 0;
            end else if (M_AXI_AWVALID) aw_wait++;
            if (w_hs) begin
               w_log.push_back(M_AXI_WDATA);
               w_data_l = M_AXI_WDATA; w_got = 1; w_wait = 0;
            end else if (M_AXI_WVALID) w_wait++;
            if (ar_hs) begin
               ar_log.push_back(M_AXI_ARADDR);
               ar_pend = 1;
            end
         end
         @(posedge ACLK);
         #1;
         if (!ARESETN) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
            M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
         end else begin
            if (b_hs) M_AXI_BVALID = 0;
            if (r_hs) M_AXI_RVALID = 0;
            if (aw_got && w_got) begin
               aw_got = 0; w_got = 0;
               if (aw_addr_l == 32'h0) reg_a = w_data_l;
               else if (aw_addr_l == 32'h4) reg_b = w_data_l;
               M_AXI_BVALID = 1;
               M_AXI_BRESP  = (aw_addr_l == 32'h4) ? bresp_b : 2'b00;
            end
            if (ar_pend) begin
               ar_pend = 0;
               M_AXI_RVALID = 1;
               M_AXI_RDATA  = rdata_over_en ? rdata_over : reg_a + reg_b;
               M_AXI_RRESP  = rresp_cfg;
            end
            M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= ((M_AXI_AWADDR == 32'h0) ? aw_delay : 0));
            M_AXI_WREADY  = M_AXI_WVALID  && (w_wait  >= ((M_AXI_AWADDR == 32'h0) ? w_delay  : 0));
            M_AXI_ARREADY = M_AXI_ARVALID;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      else
         passed++;
   endtask

   task automatic clearLogs();
      aw_log.delete(); w_log.delete(); ar_log.delete();
      aw_alone = 0; w_alone = 0;
   endtask

   // Presents one request and waits (bounded) for rsp_valid; latency counts cycles from
   // the request cycle to the first cycle rsp_valid is seen.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int latency);
      int cyc;
      @(negedge ACLK);
      req_a = a; req_b = b; req_valid = 1'b1;
      checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
      @(posedge ACLK); #1;
      req_valid = 1'b0;
      cyc = 1;
      checkOutput("awvalid_first", 32'(M_AXI_AWVALID), 32'd1);
      checkOutput("wvalid_first", 32'(M_AXI_WVALID), 32'd1);
      checkOutput("awaddr_a", M_AXI_AWADDR, 32'h0);
      checkOutput("wdata_a", M_AXI_WDATA, a);
      checkOutput("busy_set", 32'(busy), 32'd1);
      while (!rsp_valid && cyc < 200) begin
         @(posedge ACLK); #1;
         cyc++;
      end
      latency = rsp_valid ? cyc : -1;
      if (!rsp_valid) checkOutput("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic finishRsp(input logic [15:0] exp_count);
      rsp_ready = 1'b1;
      @(posedge ACLK); #1;
      rsp_ready = 1'b0;
      checkOutput("rsp_valid_clr", 32'(rsp_valid), 32'd0);
      checkOutput("req_ready_back", 32'(req_ready), 32'd1);
      checkOutput("busy_clr", 32'(busy), 32'd0);
      checkOutput("txn_count", 32'(txn_count), 32'(exp_count));
   endtask

   initial begin : stim
      int  lat;
      logic found;
      ARESETN = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
      clearLogs();
      repeat (3) @(posedge ACLK);
      #1;
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_awvalid", 32'(M_AXI_AWVALID), 32'd0);
      checkOutput("rst_arvalid", 32'(M_AXI_ARVALID), 32'd0);
      checkOutput("rst_bready", 32'(M_AXI_BREADY), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_txn", 32'(txn_count), 32'd0);
      checkOutput("rst_rsp_sum", rsp_sum, 32'd0);
      checkOutput("rst_awaddr", M_AXI_AWADDR, 32'd0);
      checkOutput("rst_wdata", M_AXI_WDATA, 32'd0);
      checkOutput("wstrb", 32'(M_AXI_WSTRB), 32'hF);
      @(negedge ACLK);
      ARESETN = 1'b1;

      $display("[TB] basic 1+2");
      clearLogs();
      applyStimulus(32'd1, 32'd2, lat);
      checkOutput("basic_latency", 32'(lat), 32'd7);
      checkOutput("basic_sum", rsp_sum, 32'd3);
      checkOutput("basic_err", 32'(rsp_err), 32'd0);
      checkOutput("basic_aw_beats", 32'(aw_log.size()), 32'd2);
      checkOutput("basic_w_beats", 32'(w_log.size()), 32'd2);
      checkOutput("basic_ar_beats", 32'(ar_log.size()), 32'd1);
      if (aw_log.size() == 2 && w_log.size() == 2 && ar_log.size() == 1) begin
         checkOutput("basic_awaddr0", aw_log[0], 32'h0);
         checkOutput("basic_awaddr1", aw_log[1], 32'h4);
         checkOutput("basic_wdata0", w_log[0], 32'h1);
         checkOutput("basic_wdata1", w_log[1], 32'h2);
         checkOutput("basic_araddr", ar_log[0], 32'h8);
      end
      finishRsp(16'd1);

      $display("[TB] overflow");
      clearLogs();
      applyStimulus(32'hFFFF_FFFF, 32'd2, lat);
      checkOutput("ovf_sum", rsp_sum, 32'h0000_0001);
      checkOutput("ovf_err", 32'(rsp_err), 32'd0);
      finishRsp(16'd2);

      $display("[TB] skew, W before AW");
      clearLogs();
      aw_delay = 3; w_delay = 0;
      applyStimulus(32'd5, 32'd6, lat);
      checkOutput("skew1_sum", rsp_sum, 32'd11);
      checkOutput("skew1_aw_alone", 32'(aw_alone), 32'd3);
      checkOutput("skew1_w_alone", 32'(w_alone), 32'd0);
      checkOutput("skew1_aw_beats", 32'(aw_log.size()), 32'd2);
      checkOutput("skew1_w_beats", 32'(w_log.size()), 32'd2);
      finishRsp(16'd3);

      $display("[TB] skew, AW before W");
      clearLogs();
      aw_delay = 0; w_delay = 3;
      applyStimulus(32'd5, 32'd6, lat);
      checkOutput("skew2_sum", rsp_sum, 32'd11);
      checkOutput("skew2_aw_alone", 32'(aw_alone), 32'd0);
      checkOutput("skew2_w_alone", 32'(w_alone), 32'd3);
      checkOutput("skew2_aw_beats", 32'(aw_log.size()), 32'd2);
      checkOutput("skew2_w_beats", 32'(w_log.size()), 32'd2);
      finishRsp(16'd4);
      w_delay = 0;

      $display("[TB] write error on B");
      clearLogs();
      bresp_b = 2'b10;
      applyStimulus(32'd9, 32'd10, lat);
      checkOutput("werr_err", 32'(rsp_err), 32'd1);
      checkOutput("werr_sum", rsp_sum, 32'd0);
      checkOutput("werr_no_ar", 32'(ar_log.size()), 32'd0);
      checkOutput("werr_w_beats", 32'(w_log.size()), 32'd2);
      finishRsp(16'd5);
      bresp_b = 2'b00;

      $display("[TB] read error with back-pressure");
      clearLogs();
      rresp_cfg = 2'b11; rdata_over_en = 1'b1; rdata_over = 32'hDEAD_BEEF;
      applyStimulus(32'd3, 32'd4, lat);
      for (int i = 0; i < 5; i++) begin
         checkOutput("rerr_valid_held", 32'(rsp_valid), 32'd1);
         checkOutput("rerr_err", 32'(rsp_err), 32'd1);
         checkOutput("rerr_sum", rsp_sum, 32'hDEAD_BEEF);
         checkOutput("rerr_req_ready", 32'(req_ready), 32'd0);
         @(posedge ACLK); #1;
      end
      finishRsp(16'd6);
      rresp_cfg = 2'b00; rdata_over_en = 1'b0;

      $display("[TB] reset during WR_B");
      clearLogs();
      @(negedge ACLK);
      req_a = 32'd100; req_b = 32'd200; req_valid = 1'b1;
      @(posedge ACLK); #1;
      req_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (M_AXI_AWVALID && M_AXI_AWADDR == 32'h4) found = 1'b1;
         else begin
            @(posedge ACLK); #1;
         end
      end
      checkOutput("wr_b_reached", 32'(found), 32'd1);
      #2 ARESETN = 1'b0;
      #1;
      checkOutput("mid_awvalid", 32'(M_AXI_AWVALID), 32'd0);
      checkOutput("mid_wvalid", 32'(M_AXI_WVALID), 32'd0);
      checkOutput("mid_bready", 32'(M_AXI_BREADY), 32'd0);
      checkOutput("mid_arvalid", 32'(M_AXI_ARVALID), 32'd0);
      checkOutput("mid_busy", 32'(busy), 32'd0);
      checkOutput("mid_req_ready", 32'(req_ready), 32'd1);
      checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("mid_txn", 32'(txn_count), 32'd0);
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

      $display("[TB] request after reset");
      clearLogs();
      applyStimulus(32'd7, 32'd8, lat);
      checkOutput("after_rst_sum", rsp_sum, 32'd15);
      checkOutput("after_rst_err", 32'(rsp_err), 32'd0);
      checkOutput("after_rst_latency", 32'(lat), 32'd7);
      finishRsp(16'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
